// File: rtl/acc_ctrl_fsm.sv
// acc_ctrl_fsm: start/validate config, issue a counted beat burst, count results, report status/error/irq
// Ports: clk, rst_n (async active-low); start_i/abort_i/clear_i pulses and cfg_len_i/cfg_mode_i from the
// register block; dp_valid_o/dp_ready_i/dp_idx_o/dp_mode_o/dp_done_i to the datapath;
// status_o/error_o/busy_o/irq_o back to the register block.
module acc_ctrl_fsm #(
  parameter int LEN_W          = 16,
  parameter int MAX_LEN        = 1024,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             clear_i,
  input  logic [LEN_W-1:0] cfg_len_i,
  input  logic [1:0]       cfg_mode_i,
  output logic             dp_valid_o,
  input  logic             dp_ready_i,
  output logic [LEN_W-1:0] dp_idx_o,
  output logic [1:0]       dp_mode_o,
  input  logic             dp_done_i,
  output logic [3:0]       status_o,
  output logic [3:0]       error_o,
  output logic             busy_o,
  output logic             irq_o
);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  typedef enum logic [3:0] {ST_IDLE = 4'h0, ST_RUNNING = 4'h1} acc_state_t;
  typedef enum logic [3:0] {ER_OKAY = 4'h0, ER_INVALID_CFG = 4'h1, ER_OTHERS = 4'h2} acc_error_t;
  acc_state_t state, state_n;
  acc_error_t error, error_n;
  logic irq, irq_n;
  logic [LEN_W-1:0] len, len_n, issued, issued_n, done_cnt, done_n;
  logic [1:0] mode, mode_n;
  logic [WD_W-1:0] wdog, wdog_n;
  logic running, cfg_ok, xfer, dn, final_done, activity;
  assign running    = state == ST_RUNNING;
  assign cfg_ok     = cfg_len_i != '0 && cfg_len_i <= MAX_L && cfg_mode_i != 2'b11;
  assign dp_valid_o = running && issued < len;
  assign xfer       = dp_valid_o && dp_ready_i;
  // done pulses beyond the burst length never reach the counter
  assign dn         = running && dp_done_i && done_cnt != len;
  assign final_done = dn && done_cnt == len - 1'b1;
  assign activity   = xfer || dp_done_i;
  assign dp_idx_o   = issued;
  assign dp_mode_o  = mode;
  assign status_o   = state;
  assign error_o    = error;
  assign busy_o     = running;
  assign irq_o      = irq;
  always_comb begin
    state_n  = state;
    error_n  = error;
    irq_n    = 1'b0;
    len_n    = len;
    mode_n   = mode;
    issued_n = issued;
    done_n   = done_cnt;
    wdog_n   = wdog;
    if (!running) begin
      if (start_i && !cfg_ok) begin
        error_n = ER_INVALID_CFG;
        irq_n   = 1'b1;
      end else if (start_i) begin
        state_n  = ST_RUNNING;
        error_n  = ER_OKAY;
        len_n    = cfg_len_i;
        mode_n   = cfg_mode_i;
        issued_n = '0;
        done_n   = '0;
        wdog_n   = '0;
      end else if (clear_i) begin
        error_n = ER_OKAY;
      end
    end else begin
      issued_n = issued + LEN_W'(xfer);
      done_n   = done_cnt + LEN_W'(dn);
      wdog_n   = activity ? '0 : wdog + 1'b1;
      // completion outranks abort, abort outranks the watchdog
      if (final_done) begin
        state_n = ST_IDLE;
        error_n = ER_OKAY;
        irq_n   = 1'b1;
      end else if (abort_i || (!activity && wdog == WD_LAST)) begin
        state_n = ST_IDLE;
        error_n = ER_OTHERS;
        irq_n   = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      error    <= ER_OKAY;
      irq      <= 1'b0;
      len      <= '0;
      mode     <= '0;
      issued   <= '0;
      done_cnt <= '0;
      wdog     <= '0;
    end else begin
      state    <= state_n;
      error    <= error_n;
      irq      <= irq_n;
      len      <= len_n;
      mode     <= mode_n;
      issued   <= issued_n;
      done_cnt <= done_n;
      wdog     <= wdog_n;
    end
  end
endmodule

// File: doc/acc_ctrl_fsm.md
Name: acc_ctrl_fsm

Overview:
Control/sequencing stage that consumes the accelerator template's state and error encodings. It drives those encodings into the status register.
- Accepts a start pulse and configuration from the register interface, and validates the configuration.
- Issues a counted burst of work beats to the datapath over a valid/ready handshake, and counts the results returned.
- Reports status, error and a completion interrupt back to the register interface.
- Sits between the APB/config register block (upstream) and the accelerator datapath (downstream).

Parameters:
LEN_W, 16, width of the length field and the beat counters.
MAX_LEN, 1024, largest legal burst length; must be <= 2**LEN_W-1.
TIMEOUT_CYCLES, 4096, number of idle cycles in RUNNING before the watchdog aborts the burst; watchdog counter is $clog2(TIMEOUT_CYCLES+1) bits wide.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
start_i  in  1  single-cycle start pulse from register write
abort_i  in  1  single-cycle software abort pulse
clear_i  in  1  single-cycle error-clear pulse
cfg_len_i  in  LEN_W  number of beats to issue
cfg_mode_i  in  2  operation mode; 2'b11 is reserved and illegal
dp_valid_o  out  1  beat valid to datapath
dp_ready_i  in  1  datapath accepts beat
dp_idx_o  out  LEN_W  index of the current beat (0..len-1)
dp_mode_o  out  2  latched mode, stable for the whole burst
dp_done_i  in  1  one result completed by datapath (pulse per beat)
status_o  out  4  acc_state_t: ST_IDLE=4'h0, ST_RUNNING=4'h1
error_o  out  4  acc_error_t: ER_OKAY=4'h0, ER_INVALID_CFG=4'h1, ER_OTHERS=4'h2
busy_o  out  1  1 while status_o==ST_RUNNING
irq_o  out  1  one-cycle end-of-operation pulse

Behaviour:
Reset: on asynchronous reset all outputs and registers go to their idle values.
- status_o=ST_IDLE, error_o=ER_OKAY.
- dp_valid_o, busy_o and irq_o = 0.
- dp_idx_o, dp_mode_o, all counters and the latched length = 0.
- Reset mid-burst aborts the burst immediately, with no irq_o.

IDLE:
- start_i with cfg_len_i==0, cfg_len_i>MAX_LEN, or cfg_mode_i==2'b11: error_o=ER_INVALID_CFG and irq_o=1 on the next cycle; state stays IDLE.
- start_i with a legal config:
  - latch len and mode; clear issued, done and watchdog counters;
  - error_o=ER_OKAY;
  - next cycle status_o=ST_RUNNING and dp_valid_o=1 with dp_idx_o=0.
- clear_i sets error_o=ER_OKAY. If start_i and clear_i arrive together, start_i's result wins.
- dp_done_i, dp_ready_i and abort_i are ignored.

RUNNING:
- dp_valid_o=1 while issued<len. A beat transfers when dp_valid_o&&dp_ready_i; on transfer issued and dp_idx_o increment.
- Once valid is asserted, dp_valid_o does not drop and dp_idx_o does not change until the beat transfers (abort and reset are the only exceptions).
- After the last transfer, dp_valid_o=0 in the following cycle.
- Each dp_done_i pulse increments the done counter. Pulses beyond len are ignored.
- When done reaches len: next cycle status_o=ST_IDLE, irq_o=1 for one cycle, error_o=ER_OKAY.
- Watchdog:
  - clears on any transfer or dp_done_i, otherwise increments;
  - on reaching TIMEOUT_CYCLES: abort, status_o=ST_IDLE, error_o=ER_OTHERS, irq_o=1.
- abort_i: next cycle status_o=ST_IDLE, dp_valid_o=0, error_o=ER_OTHERS, irq_o=1.
- start_i and clear_i are ignored.

Priority in the same cycle: reset > completion (final dp_done_i) > abort_i > watchdog.

Fixed timing:
- Latency from start_i to the first beat valid is 1 cycle.
- Latency from the final dp_done_i to irq_o is 1 cycle.
- dp_mode_o holds its value after the burst until the next legal start.

Test Plan:
- Legal run: cfg_len=4, mode=0, start, dp_ready held 1, dp_done 2 cycles after each beat.
  - Required: beats idx 0,1,2,3 on consecutive cycles; status 1 during the burst; irq pulses once, 1 cycle after the 4th done; status 0, error 0.
- Backpressure: cfg_len=3, dp_ready toggled 0/1 randomly.
  - Required: valid and idx stable while ready=0; exactly 3 transfers; no idx skips.
- Invalid config: start with len=0, then len=1025, then mode=3.
  - Required: each gives error=1, status stays 0, one irq per attempt, dp_valid never asserted.
  - Then clear_i gives error=0.
- Watchdog: TIMEOUT_CYCLES=16, len=2, dp_ready=0 throughout.
  - Required: 16 cycles after entering RUNNING, status=0, error=2, irq pulses, dp_valid drops.
- Abort and collisions:
  - abort_i mid-burst gives error=2 and irq.
  - abort_i in the same cycle as the final dp_done gives completion (error=0).
  - start_i while RUNNING is ignored (len unchanged).
  - Extra dp_done pulses are ignored.
- Reset mid-burst: assert rst_n=0 asynchronously at beat 2 of 8.
  - Required: all outputs return to reset values immediately, no irq.
  - A fresh start afterwards runs a full 8-beat burst correctly.
